// File: rtl/render_pkg.sv
// Shared definitions for the rectangle renderer family.
// Holds default screen geometry and bus widths, the draw FSM state encoding
// and the named 3-bit palette colors.
package render_pkg;

  localparam int unsigned DEF_SCREEN_W = 320;
  localparam int unsigned DEF_SCREEN_H = 240;
  localparam int unsigned DEF_XW       = 9;
  localparam int unsigned DEF_YW       = 8;
  localparam int unsigned DEF_CW       = 3;
  localparam int unsigned DEF_BW       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major column/row scan counter over a width x height area.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   clear_i           return to (0,0); wins over advance_i
//   advance_i         step to the next position in row-major order
//   width_i/height_i  scan limits (both must be non-zero while advancing)
//   col_o/row_o       current position
//   wrap_o            current column is the last one of the row
//   last_o            current position is the final one of the area
module rect_scan_counter #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          advance_i,
  input  logic [XW-1:0] width_i,
  input  logic [YW-1:0] height_i,
  output logic [XW-1:0] col_o,
  output logic [YW-1:0] row_o,
  output logic          wrap_o,
  output logic          last_o
);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign wrap_o = (col_q == width_i - XW'(1));
  assign last_o = wrap_o && (row_q == height_i - YW'(1));

  // Next position: clear, step along the row, or wrap to the next row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (wrap_o) begin
        col_d = '0;
        row_d = row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/render_rect_gen.sv
// Rectangle rasteriser: streams one pixel per beat (x, y, color, writeEn)
// with border, off-screen clipping, start/busy/done and ready backpressure.
// Ports:
//   clk, resetn            clock, async active-low reset
//   start                  draw request, taken only in IDLE or DONE
//   origin_x/origin_y      top-left corner
//   width/height           size in pixels (zero size finishes immediately)
//   back_color             interior color
//   border_thick/_color    border thickness (0 = none) and color
//   checker_color          second interior color (RENDER_RECT_CHECKER_EN only)
//   ready                  downstream accepts the presented pixel
//   busy/done              drawing / finished status
//   x_stream, y_stream, color_stream, writeEn   registered pixel stream
// Optional feature macro: RENDER_RECT_CHECKER_EN (checkerboard interior).
module render_rect_gen
  import render_pkg::*;
#(
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned XW       = DEF_XW,
  parameter int unsigned YW       = DEF_YW,
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned BW       = DEF_BW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] origin_x,
  input  logic [YW-1:0] origin_y,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  input  logic [CW-1:0] back_color,
  input  logic [BW-1:0] border_thick,
  input  logic [CW-1:0] border_color,
`ifdef RENDER_RECT_CHECKER_EN
  input  logic [CW-1:0] checker_color,
`endif
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_stream,
  output logic [YW-1:0] y_stream,
  output logic [CW-1:0] color_stream,
  output logic          writeEn
);

  localparam int unsigned PXW = XW + 1;
  localparam int unsigned PYW = YW + 1;

  state_e        state_q, state_d;
  logic [XW-1:0] ox_q, w_q;
  logic [YW-1:0] oy_q, h_q;
  logic [CW-1:0] back_q, brd_q;
  logic [BW-1:0] bt_q;
`ifdef RENDER_RECT_CHECKER_EN
  logic [CW-1:0] chk_q;
`endif
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] color_q, color_d;
  logic          we_q, we_d, busy_q, done_q;

  logic          accept, adv, clr, pix_load;
  logic [XW-1:0] col, s_ox, s_w, s_col;
  logic [YW-1:0] row, s_oy, s_h, s_row;
  logic [CW-1:0] s_back, s_brd, pix_color;
  logic [BW-1:0] s_bt;
  logic          wrap, last, vis, border;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;

  rect_scan_counter #(.XW(XW), .YW(YW)) u_scan (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .clear_i  (clr),
    .advance_i(adv),
    .width_i  (w_q),
    .height_i (h_q),
    .col_o    (col),
    .row_o    (row),
    .wrap_o   (wrap),
    .last_o   (last)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // The output registers carry the pixel being presented, so the next pixel
  // is evaluated ahead: (0,0) from the live inputs on start, else the
  // position the counter is about to step to, from the shadow registers.
  assign s_ox   = accept ? origin_x     : ox_q;
  assign s_oy   = accept ? origin_y     : oy_q;
  assign s_w    = accept ? width        : w_q;
  assign s_h    = accept ? height       : h_q;
  assign s_bt   = accept ? border_thick : bt_q;
  assign s_back = accept ? back_color   : back_q;
  assign s_brd  = accept ? border_color : brd_q;
  assign s_col  = (accept || wrap) ? '0 : col + XW'(1);
  assign s_row  = accept ? '0 : (wrap ? row + YW'(1) : row);

  // Widened sums so coordinates past the top of the XW/YW range still clip.
  assign px  = PXW'(s_ox) + PXW'(s_col);
  assign py  = PYW'(s_oy) + PYW'(s_row);
  assign vis = (px < PXW'(SCREEN_W)) && (py < PYW'(SCREEN_H));

  // col >= w-bt is evaluated as col+bt >= w to avoid unsigned underflow.
  assign border = (s_bt != '0) &&
                  ((PXW'(s_col) < PXW'(s_bt)) ||
                   (PXW'(s_col) + PXW'(s_bt) >= PXW'(s_w)) ||
                   (PYW'(s_row) < PYW'(s_bt)) ||
                   (PYW'(s_row) + PYW'(s_bt) >= PYW'(s_h)));

`ifdef RENDER_RECT_CHECKER_EN
  logic [CW-1:0] s_chk;
  assign s_chk     = accept ? checker_color : chk_q;
  assign pix_color = border ? s_brd : ((px[0] ^ py[0]) ? s_chk : s_back);
`else
  assign pix_color = border ? s_brd : s_back;
`endif

  // Next state, counter control and pixel register updates.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    adv      = 1'b0;
    clr      = 1'b0;
    pix_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        we_d = 1'b0;
        if (start) begin
          clr = 1'b1;
          if ((width == '0) || (height == '0)) begin
            state_d = DONE;
          end else begin
            state_d  = DRAW;
            we_d     = vis;
            pix_load = vis;
          end
        end
      end
      DRAW: begin
        // Clipped beats never wait on ready.
        if (!we_q || ready) begin
          if (last) begin
            state_d = DONE;
            we_d    = 1'b0;
          end else begin
            adv      = 1'b1;
            we_d     = vis;
            pix_load = vis;
          end
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
    if (pix_load) begin
      x_d     = XW'(px);
      y_d     = YW'(py);
      color_d = pix_color;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      busy_q  <= (state_d == DRAW);
      done_q  <= (state_d == DONE);
    end
  end

  // Draw attributes frozen at start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ox_q   <= '0;
      oy_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      back_q <= '0;
      brd_q  <= '0;
      bt_q   <= '0;
`ifdef RENDER_RECT_CHECKER_EN
      chk_q  <= '0;
`endif
    end else if (accept) begin
      ox_q   <= origin_x;
      oy_q   <= origin_y;
      w_q    <= width;
      h_q    <= height;
      back_q <= back_color;
      brd_q  <= border_color;
      bt_q   <= border_thick;
`ifdef RENDER_RECT_CHECKER_EN
      chk_q  <= checker_color;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign x_stream     = x_q;
  assign y_stream     = y_q;
  assign color_stream = color_q;
  assign writeEn      = we_q;

endmodule
